blvds_halfduplex_link: RTL and testbench

- Half-duplex framed serial link controller sitting directly upstream of the Cyclone III bidirectional LVDS buffer.
- Drives the buffer's oe and doutp, and consumes its din.
- Serializes parallel words onto the shared differential pair, inserts bus-turnaround guard time, and deserializes received frames when the pair is released.
- Gives the system a single-wire-pair bidirectional word channel.

---
 rtl/blvds_halfduplex_link.sv | 190 +++++++++++++++++++
 tb/tb_blvds_halfduplex_link.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/blvds_halfduplex_link.sv
// Half-duplex framed serial link for a bidirectional LVDS buffer: serializes words with
// turnaround guard time while driving the pair, and deserializes frames when it is released.
module blvds_halfduplex_link #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned BIT_DIV  = 16,
    parameter int unsigned TURN_CYC = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_frame_err,
    output logic              busy,
    output logic              oe,
    output logic              doutp,
    input  logic              din
);

    localparam int unsigned FRAME_W = DATA_W + 2;
    localparam int unsigned CNT_MAX = (BIT_DIV > TURN_CYC) ? BIT_DIV : TURN_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned BIT_W   = $clog2(FRAME_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX_LEAD,
        S_TX_SHIFT,
        S_TX_TRAIL,
        S_BLANK,
        S_RX_START,
        S_RX_SHIFT,
        S_RX_STOPWAIT
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [FRAME_W-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0]  rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0]  rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               rx_err_q, rx_err_d;
    logic               tx_ready_q, tx_ready_d;
    logic               busy_q, busy_d;
    logic               oe_q, oe_d;
    logic               doutp_q, doutp_d;
    logic               sync1_q, sync2_q;
    logic               din_s;

    assign din_s = sync2_q;

    // Two-flop synchronizer; resets to the idle-high line level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            tx_sh_q    <= '1;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            oe_q       <= 1'b0;
            doutp_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_err_q   <= rx_err_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
            oe_q       <= oe_d;
            doutp_q    <= doutp_d;
        end
    end

    // Next state; outputs are derived from the next state so the registers match it
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        bit_d      = bit_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (!din_s) begin
                    state_d = S_RX_START;
                end else if (tx_valid && tx_ready_q) begin
                    tx_sh_d = {1'b1, tx_data, 1'b0};
                    state_d = S_TX_LEAD;
                end
            end
            S_TX_LEAD: begin
                if (cnt_q == CNT_W'(TURN_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = S_TX_SHIFT;
                end
            end
            S_TX_SHIFT: begin
                if (cnt_q == CNT_W'(BIT_DIV - 1)) begin
                    cnt_d   = '0;
                    tx_sh_d = {1'b1, tx_sh_q[FRAME_W-1:1]};
                    bit_d   = bit_q + BIT_W'(1);
                    if (bit_q == BIT_W'(FRAME_W - 1)) begin
                        state_d = S_TX_TRAIL;
                    end
                end
            end
            S_TX_TRAIL: begin
                if (cnt_q == CNT_W'(TURN_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = S_BLANK;
                end
            end
            S_BLANK: begin
                // Lets our own echo drain out of the synchronizer
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_IDLE;
                end
            end
            S_RX_START: begin
                if (cnt_q == CNT_W'(BIT_DIV / 2 - 1)) begin
                    cnt_d   = '0;
                    state_d = din_s ? S_IDLE : S_RX_SHIFT;
                end
            end
            S_RX_SHIFT: begin
                if (cnt_q == CNT_W'(BIT_DIV - 1)) begin
                    cnt_d = '0;
                    if (bit_q == BIT_W'(DATA_W)) begin
                        rx_data_d  = rx_sh_q;
                        rx_valid_d = 1'b1;
                        rx_err_d   = ~din_s;
                        state_d    = S_RX_STOPWAIT;
                    end else begin
                        rx_sh_d = {din_s, rx_sh_q[DATA_W-1:1]};
                        bit_d   = bit_q + BIT_W'(1);
                    end
                end
            end
            S_RX_STOPWAIT: begin
                cnt_d = '0;
                if (din_s) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        oe_d       = (state_d == S_TX_LEAD) || (state_d == S_TX_SHIFT) || (state_d == S_TX_TRAIL);
        doutp_d    = (state_d == S_TX_SHIFT) ? tx_sh_d[0] : 1'b1;
        busy_d     = (state_d != S_IDLE);
        tx_ready_d = (state_d == S_IDLE) && sync1_q;
    end

    assign tx_ready     = tx_ready_q;
    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_frame_err = rx_err_q;
    assign busy         = busy_q;
    assign oe           = oe_q;
    assign doutp        = doutp_q;

endmodule

// File: tb/tb_blvds_halfduplex_link.sv
// Directed bench for blvds_halfduplex_link; the pad is modelled as doutp when oe=1,
// otherwise the level the bench drives onto the line.
module tb_blvds_halfduplex_link;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned BIT_DIV  = 16;
    localparam int unsigned TURN_CYC = 4;
    localparam int unsigned OE_CYC   = 168;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_frame_err;
    logic              busy;
    logic              oe;
    logic              doutp;
    logic              din;
    logic              line;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rx_cnt   = 0;
    int rx_at    = 0;
    logic [DATA_W-1:0] rx_last = '0;
    logic              rx_last_err = 1'b0;

    assign din = oe ? doutp : line;

    always #5 clk = ~clk;

    blvds_halfduplex_link #(
        .DATA_W  (DATA_W),
        .BIT_DIV (BIT_DIV),
        .TURN_CYC(TURN_CYC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_frame_err(rx_frame_err),
        .busy        (busy),
        .oe          (oe),
        .doutp       (doutp),
        .din         (din)
    );

    // Records every rx_valid pulse and the cycle it appeared in
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rx_valid) begin
            rx_cnt      <= rx_cnt + 1;
            rx_last     <= rx_data;
            rx_last_err <= rx_frame_err;
            rx_at       <= cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected pad level i cycles into an oe-high window
    function automatic logic exp_bit(input logic [DATA_W-1:0] d, input int i);
        int b;
        if (i < int'(TURN_CYC)) return 1'b1;
        if (i >= int'(TURN_CYC + (DATA_W + 2) * BIT_DIV)) return 1'b1;
        b = (i - int'(TURN_CYC)) / int'(BIT_DIV);
        if (b == 0) return 1'b0;
        if (b == int'(DATA_W) + 1) return 1'b1;
        return d[b-1];
    endfunction

    task automatic watch_tx(input string tag, input logic [DATA_W-1:0] d);
        int i;
        int bad;
        int w;
        w = 0;
        while (!oe && w < 400) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_start"}, 32'(oe), 32'd1);
        tx_valid = 1'b0;
        bad = 0;
        i = 0;
        while (oe && i < 400) begin
            if (doutp !== exp_bit(d, i)) bad++;
            i++;
            @(negedge clk);
        end
        check({tag, "_oe_len"}, 32'(i), 32'(OE_CYC));
        check({tag, "_bits"}, 32'(bad), 32'd0);
        check({tag, "_blank_rdy"}, 32'(tx_ready), 32'd0);
        repeat (2) @(negedge clk);
        check({tag, "_rdy"}, 32'(tx_ready), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] d, input logic stop);
        logic [DATA_W+1:0] f;
        f = {stop, d, 1'b0};
        for (int k = 0; k < DATA_W + 2; k++) begin
            line = f[k];
            repeat (BIT_DIV) @(negedge clk);
        end
        line = 1'b1;
    endtask

    initial begin
        int base;
        int start;
        int rdy_hi;
        int n;
        line     = 1'b1;
        tx_valid = 1'b0;
        tx_data  = '0;
        reset    = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_oe", 32'(oe), 32'd0);
        check("rst_doutp", 32'(doutp), 32'd1);
        check("rst_tx_ready", 32'(tx_ready), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_frame_err", 32'(rx_frame_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rdy_after_rst", 32'(tx_ready), 32'd1);

        // Transmit A5; the pad echoes back and must not be received
        base     = rx_cnt;
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        @(negedge clk);
        check("tx_latency", 32'(oe), 32'd1);
        watch_tx("a5", 8'hA5);
        repeat (10) @(negedge clk);
        check("echo_rx", 32'(rx_cnt - base), 32'd0);

        // Good frame 3C
        base  = rx_cnt;
        start = cyc;
        send_frame(8'h3C, 1'b1);
        repeat (20) @(negedge clk);
        check("rx_count", 32'(rx_cnt - base), 32'd1);
        check("rx_data", 32'(rx_last), 32'h3C);
        check("rx_err", 32'(rx_last_err), 32'd0);
        check("rx_latency_ok", 32'((rx_at - start >= 153) && (rx_at - start <= 156)), 32'd1);
        check("rx_valid_low", 32'(rx_valid), 32'd0);

        // Stop bit driven low
        base = rx_cnt;
        send_frame(8'h3C, 1'b0);
        repeat (20) @(negedge clk);
        check("ferr_count", 32'(rx_cnt - base), 32'd1);
        check("ferr_data", 32'(rx_last), 32'h3C);
        check("ferr_err", 32'(rx_last_err), 32'd1);
        check("ferr_cleared", 32'(rx_frame_err), 32'd0);

        // Short low glitch is rejected
        base = rx_cnt;
        line = 1'b0;
        repeat (5) @(negedge clk);
        line = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_rx", 32'(rx_cnt - base), 32'd0);
        check("glitch_rdy", 32'(tx_ready), 32'd1);
        check("glitch_busy", 32'(busy), 32'd0);

        // tx_valid rises in the cycle din_s falls: receive first, then transmit
        base    = rx_cnt;
        tx_data = 8'h96;
        rdy_hi  = 0;
        n       = 0;
        fork
            send_frame(8'h3C, 1'b1);
            begin
                repeat (2) @(negedge clk);
                tx_valid = 1'b1;
                while (rx_cnt == base && n < 300) begin
                    if (tx_ready || oe) rdy_hi++;
                    @(negedge clk);
                    n++;
                end
            end
        join_any
        check("simul_rx_seen", 32'(rx_cnt - base), 32'd1);
        check("simul_rx_data", 32'(rx_last), 32'h3C);
        check("simul_rdy_during_rx", 32'(rdy_hi), 32'd0);
        n = 0;
        while (!oe && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("simul_tx_delay", 32'((n >= 1) && (n <= 3)), 32'd1);
        watch_tx("simul", 8'h96);
        repeat (10) @(negedge clk);

        // Reset 50 cycles into the shift phase
        base     = rx_cnt;
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("mid_oe_up", 32'(oe), 32'd1);
        repeat (TURN_CYC + 50) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_oe", 32'(oe), 32'd0);
        check("mid_rst_doutp", 32'(doutp), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_rdy", 32'(tx_ready), 32'd1);
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        watch_tx("post_rst", 8'hC3);
        repeat (10) @(negedge clk);
        check("post_rst_no_rx", 32'(rx_cnt - base), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
